// File: rtl/bottling_pkg.sv
// bottling_pkg: shared types and default constants for the bottling plant model.
// Holds the plant state encoding, default timing, hopper capacity and the
// pill-jitter LFSR seed/taps used when PILL_JITTER_EN is defined.
package bottling_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DROP_HI = 3'd1,
        DROP_LO = 3'd2,
        MOVING  = 3'd3,
        JAMMED  = 3'd4
    } plant_state_e;

    localparam int unsigned DEF_PILL_PERIOD = 1000;
    localparam int unsigned DEF_PULSE_HI    = 500;
    localparam int unsigned DEF_MOVE_TIME   = 2000;
    localparam int unsigned DEF_HOPPER_CAP  = 999;

    // x^8 + x^6 + x^5 + x^4 + 1, left-shifting Fibonacci form
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // 10-bit increment that sticks at all-ones
    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/bottling_plant_model_pill_lfsr.sv
// pill_lfsr: 8-bit LFSR stepping once per pill; exposes the top nibble as the
// extra low-phase length. Only exists in builds with PILL_JITTER_EN defined.
`ifdef PILL_JITTER_EN
module pill_lfsr
    import bottling_pkg::*;
(
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic       step,
    output logic [3:0] jitter
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Shift in the tap parity whenever a new pill starts
    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // LFSR register, seeded on reset
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign jitter = lfsr_q[7:4];

endmodule
`endif

// File: rtl/bottling_plant_model.sv
// bottling_plant_model: hopper pill feeder plus bottle conveyor, the plant side
// of the bottling controller interface. Optional macro PILL_JITTER_EN adds 0-15
// pseudo-random cycles to every pill's low phase.
// The low phase is split into DROP_LO plus the single IDLE cycle in which the
// next pill may start, so continuous filling gives exactly PILL_PERIOD cycles
// between rising edges. PILL_PERIOD - PULSE_HI must be at least 2.
module bottling_plant_model
    import bottling_pkg::*;
#(
    parameter int unsigned PILL_PERIOD = DEF_PILL_PERIOD,
    parameter int unsigned PULSE_HI    = DEF_PULSE_HI,
    parameter int unsigned MOVE_TIME   = DEF_MOVE_TIME,
    parameter int unsigned HOPPER_CAP  = DEF_HOPPER_CAP
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic       fill_en,
    input  logic       advance_req,
    input  logic       hopper_refill,
    input  logic       inject_hopper_empty,
    input  logic       inject_conveyor_jam,
    output logic       hopper_level,
    output logic       conveyor_signal,
    output logic       bottle_in_place,
    output logic       hopper_empty,
    output logic [9:0] hopper_count,
    output logic [9:0] pills_in_bottle
);

    localparam int unsigned PH_W = $clog2(PILL_PERIOD) + 1;
    localparam int unsigned MV_W = $clog2(MOVE_TIME) + 1;

    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] HI_LOAD = PH_W'(PULSE_HI - 1);
    localparam logic [PH_W-1:0] LO_LOAD = PH_W'(PILL_PERIOD - PULSE_HI - 2);
    localparam logic [MV_W-1:0] MV_ONE  = MV_W'(1);
    localparam logic [MV_W-1:0] MV_LOAD = MV_W'(MOVE_TIME);
    localparam logic [9:0]      CAP     = 10'(HOPPER_CAP);

    plant_state_e    state_q, state_d;
    logic [PH_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [MV_W-1:0] move_cnt_q, move_cnt_d;
    logic [9:0]      hopper_count_q, hopper_count_d;
    logic [9:0]      pills_in_bottle_q, pills_in_bottle_d;
    logic            advance_prev_q, advance_prev_d;
    logic            advance_pend_q, advance_pend_d;
    logic            conveyor_signal_q, conveyor_signal_d;

    logic            advance_edge;
    logic            can_feed;
    logic            pill_start;
    logic            move_start;
    logic            move_step;
    logic            move_done;
    logic [PH_W-1:0] lo_extra;

    assign advance_edge = advance_req & ~advance_prev_q;
    assign can_feed     = fill_en & bottle_in_place & ~hopper_empty;
    assign pill_start   = (state_q == IDLE) && (state_d == DROP_HI);
    assign move_start   = (state_q == IDLE) && (state_d == MOVING);
    // A move counts down in MOVING, and also on the cycle JAMMED releases
    assign move_step    = ((state_q == MOVING) || (state_q == JAMMED)) && !inject_conveyor_jam;
    assign move_done    = move_step && (move_cnt_q == MV_ONE);

`ifdef PILL_JITTER_EN
    logic [3:0] jitter;

    pill_lfsr u_pill_lfsr (
        .clk_1khz (clk_1khz),
        .rst_n    (rst_n),
        .step     (pill_start),
        .jitter   (jitter)
    );

    assign lo_extra = PH_W'(jitter);
`else
    assign lo_extra = '0;
`endif

    // State register
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: pending/new advance wins over feeding in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (advance_edge || advance_pend_q) begin
                    state_d = MOVING;
                end else if (can_feed) begin
                    state_d = DROP_HI;
                end
            end
            DROP_HI: if (phase_cnt_q == '0) state_d = DROP_LO;
            DROP_LO: if (phase_cnt_q == '0) state_d = IDLE;
            MOVING: begin
                if (inject_conveyor_jam) begin
                    state_d = JAMMED;
                end else if (move_done) begin
                    state_d = IDLE;
                end
            end
            JAMMED: begin
                if (!inject_conveyor_jam) begin
                    state_d = move_done ? IDLE : MOVING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state and counters
    always_comb begin
        hopper_level    = (state_q == DROP_HI);
        bottle_in_place = (state_q != MOVING) && (state_q != JAMMED);
        conveyor_signal = conveyor_signal_q;
        hopper_empty    = (hopper_count_q == '0) || inject_hopper_empty;
        hopper_count    = hopper_count_q;
        pills_in_bottle = pills_in_bottle_q;
    end

    // Counter, hopper, bottle and advance-tracking next values
    always_comb begin
        phase_cnt_d       = phase_cnt_q;
        move_cnt_d        = move_cnt_q;
        hopper_count_d    = hopper_count_q;
        pills_in_bottle_d = pills_in_bottle_q;
        advance_prev_d    = advance_req;
        advance_pend_d    = advance_pend_q;
        conveyor_signal_d = !inject_conveyor_jam;

        case (state_q)
            IDLE: if (pill_start) phase_cnt_d = HI_LOAD;
            DROP_HI: phase_cnt_d = (phase_cnt_q == '0) ? LO_LOAD + lo_extra : phase_cnt_q - PH_ONE;
            DROP_LO: if (phase_cnt_q != '0) phase_cnt_d = phase_cnt_q - PH_ONE;
            default: phase_cnt_d = phase_cnt_q;
        endcase

        if (move_start) begin
            move_cnt_d = MV_LOAD;
        end else if (move_step) begin
            move_cnt_d = move_cnt_q - MV_ONE;
        end

        if (pill_start) begin
            if (hopper_count_q != '0) hopper_count_d = hopper_count_q - 10'd1;
            pills_in_bottle_d = sat_inc10(pills_in_bottle_q);
        end
        if (hopper_refill) begin
            hopper_count_d = CAP;
        end
        if (move_done) begin
            pills_in_bottle_d = '0;
        end

        if (((state_q == DROP_HI) || (state_q == DROP_LO)) && advance_edge) begin
            advance_pend_d = 1'b1;
        end else if (move_start) begin
            advance_pend_d = 1'b0;
        end
    end

    // Datapath and bookkeeping registers
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt_q       <= '0;
            move_cnt_q        <= '0;
            hopper_count_q    <= CAP;
            pills_in_bottle_q <= '0;
            advance_prev_q    <= 1'b0;
            advance_pend_q    <= 1'b0;
            conveyor_signal_q <= 1'b1;
        end else begin
            phase_cnt_q       <= phase_cnt_d;
            move_cnt_q        <= move_cnt_d;
            hopper_count_q    <= hopper_count_d;
            pills_in_bottle_q <= pills_in_bottle_d;
            advance_prev_q    <= advance_prev_d;
            advance_pend_q    <= advance_pend_d;
            conveyor_signal_q <= conveyor_signal_d;
        end
    end

endmodule

// File: tb/tb_bottling_plant_model.sv
// tb_bottling_plant_model: directed bench for the bottling plant model with
// PILL_PERIOD=10, PULSE_HI=5, MOVE_TIME=20, HOPPER_CAP=3. Cycle c is the
// falling edge following the c-th rising edge after reset release.
module tb_bottling_plant_model;

    logic       clk_1khz = 1'b0;
    logic       rst_n = 1'b1;
    logic       fill_en = 1'b0;
    logic       advance_req = 1'b0;
    logic       hopper_refill = 1'b0;
    logic       inject_hopper_empty = 1'b0;
    logic       inject_conveyor_jam = 1'b0;
    logic       hopper_level;
    logic       conveyor_signal;
    logic       bottle_in_place;
    logic       hopper_empty;
    logic [9:0] hopper_count;
    logic [9:0] pills_in_bottle;

    int n_cmp = 0;
    int n_err = 0;
    int n_rise;
    int rise_at [4];
    int n_low;
    int first_low;
    int n_conv_low;
    int first_conv_low;
    int bottle_rise;
    int n_high;
    logic prev_lvl;
    logic prev_bottle;

    always #5 clk_1khz = ~clk_1khz;

    bottling_plant_model #(
        .PILL_PERIOD (10),
        .PULSE_HI    (5),
        .MOVE_TIME   (20),
        .HOPPER_CAP  (3)
    ) dut (
        .clk_1khz            (clk_1khz),
        .rst_n               (rst_n),
        .fill_en             (fill_en),
        .advance_req         (advance_req),
        .hopper_refill       (hopper_refill),
        .inject_hopper_empty (inject_hopper_empty),
        .inject_conveyor_jam (inject_conveyor_jam),
        .hopper_level        (hopper_level),
        .conveyor_signal     (conveyor_signal),
        .bottle_in_place     (bottle_in_place),
        .hopper_empty        (hopper_empty),
        .hopper_count        (hopper_count),
        .pills_in_bottle     (pills_in_bottle)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Assert reset at a falling edge and hold it; caller releases
    task automatic do_reset(input logic fill);
        @(negedge clk_1khz);
        rst_n = 1'b0;
        fill_en = fill;
        advance_req = 1'b0;
        hopper_refill = 1'b0;
        inject_hopper_empty = 1'b0;
        inject_conveyor_jam = 1'b0;
        @(negedge clk_1khz);
        @(negedge clk_1khz);
    endtask

    task automatic clear_stats();
        n_rise = 0;
        for (int i = 0; i < 4; i++) rise_at[i] = 0;
        n_low = 0;
        first_low = 0;
        n_conv_low = 0;
        first_conv_low = 0;
        bottle_rise = 0;
        n_high = 0;
        prev_lvl = 1'b0;
        prev_bottle = 1'b1;
    endtask

    task automatic track();
        if (hopper_level && !prev_lvl) begin
            if (n_rise < 4) rise_at[n_rise] = 0;
            n_rise++;
        end
        prev_lvl = hopper_level;
    endtask

    initial begin
        // Continuous fill from reset drains the 3-pill hopper
        do_reset(1'b1);
        check_val("rst_level", 32'(hopper_level), 0);
        check_val("rst_conveyor", 32'(conveyor_signal), 1);
        check_val("rst_bottle", 32'(bottle_in_place), 1);
        check_val("rst_count", 32'(hopper_count), 3);
        check_val("rst_pills", 32'(pills_in_bottle), 0);
        check_val("rst_empty", 32'(hopper_empty), 0);
        rst_n = 1'b1;
        clear_stats();
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk_1khz);
            if (hopper_level && !prev_lvl) begin
                if (n_rise < 4) rise_at[n_rise] = c;
                n_rise++;
            end
            prev_lvl = hopper_level;
            if (c == 1)  check_val("a_count_c1", 32'(hopper_count), 2);
            if (c == 5)  check_val("a_high_c5", 32'(hopper_level), 1);
            if (c == 6)  check_val("a_low_c6", 32'(hopper_level), 0);
            if (c == 11) check_val("a_count_c11", 32'(hopper_count), 1);
            if (c == 20) check_val("a_empty_c20", 32'(hopper_empty), 0);
            if (c == 21) begin
                check_val("a_count_c21", 32'(hopper_count), 0);
                check_val("a_empty_c21", 32'(hopper_empty), 1);
            end
        end
        check_val("a_n_rise", n_rise, 3);
        check_val("a_rise0", rise_at[0], 1);
        check_val("a_rise1", rise_at[1], 11);
        check_val("a_rise2", rise_at[2], 21);
        check_val("a_pills", 32'(pills_in_bottle), 3);

        // Refill an empty hopper; feeding resumes on the following edge
        hopper_refill = 1'b1;
        @(negedge clk_1khz);
        hopper_refill = 1'b0;
        check_val("r_count", 32'(hopper_count), 3);
        check_val("r_empty", 32'(hopper_empty), 0);
        check_val("r_level0", 32'(hopper_level), 0);
        @(negedge clk_1khz);
        check_val("r_level1", 32'(hopper_level), 1);
        check_val("r_count1", 32'(hopper_count), 2);
        check_val("r_pills", 32'(pills_in_bottle), 4);

        // Advance pulse during the second pill's low phase is pended
        do_reset(1'b1);
        rst_n = 1'b1;
        clear_stats();
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk_1khz);
            if (hopper_level && !prev_lvl) begin
                if (n_rise < 4) rise_at[n_rise] = c;
                n_rise++;
            end
            prev_lvl = hopper_level;
            if (!bottle_in_place) begin
                if (n_low == 0) first_low = c;
                n_low++;
            end
            if (c == 16) advance_req = 1'b1;
            if (c == 17) advance_req = 1'b0;
            if (c == 20) check_val("b_pills_c20", 32'(pills_in_bottle), 2);
            if (c == 40) check_val("b_bottle_c40", 32'(bottle_in_place), 0);
            if (c == 41) begin
                check_val("b_bottle_c41", 32'(bottle_in_place), 1);
                check_val("b_pills_c41", 32'(pills_in_bottle), 0);
            end
        end
        check_val("b_first_low", first_low, 21);
        check_val("b_n_low", n_low, 20);
        check_val("b_n_rise", n_rise, 3);
        check_val("b_rise2", rise_at[2], 42);
        check_val("b_count", 32'(hopper_count), 0);

        // Jam 5 cycles into a move for 7 cycles stretches it to 27
        do_reset(1'b0);
        rst_n = 1'b1;
        advance_req = 1'b1;
        clear_stats();
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk_1khz);
            if (!conveyor_signal) begin
                if (n_conv_low == 0) first_conv_low = c;
                n_conv_low++;
            end
            if (!bottle_in_place) n_low++;
            if (bottle_in_place && !prev_bottle) bottle_rise = c;
            prev_bottle = bottle_in_place;
            if (hopper_level) n_high++;
            if (c == 1) advance_req = 1'b0;
            if (c == 3) advance_req = 1'b1;
            if (c == 4) advance_req = 1'b0;
            if (c == 5) inject_conveyor_jam = 1'b1;
            if (c == 12) inject_conveyor_jam = 1'b0;
        end
        check_val("c_first_conv_low", first_conv_low, 6);
        check_val("c_n_conv_low", n_conv_low, 7);
        check_val("c_n_bottle_low", n_low, 27);
        check_val("c_bottle_rise", bottle_rise, 28);
        check_val("c_no_pulse", n_high, 0);

        // Dropping fill one cycle into a pulse keeps the full pulse
        do_reset(1'b1);
        rst_n = 1'b1;
        clear_stats();
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk_1khz);
            if (hopper_level && !prev_lvl) n_rise++;
            prev_lvl = hopper_level;
            if (hopper_level) n_high++;
            if (c == 1) fill_en = 1'b0;
        end
        check_val("d_n_high", n_high, 5);
        check_val("d_n_rise", n_rise, 1);
        check_val("d_count", 32'(hopper_count), 2);

        // Reset mid-pulse clears outputs asynchronously, no residual pulse
        do_reset(1'b1);
        rst_n = 1'b1;
        @(negedge clk_1khz);
        @(negedge clk_1khz);
        check_val("e_level_pre", 32'(hopper_level), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("e_level_async", 32'(hopper_level), 0);
        check_val("e_count", 32'(hopper_count), 3);
        check_val("e_pills", 32'(pills_in_bottle), 0);
        check_val("e_bottle", 32'(bottle_in_place), 1);
        check_val("e_conveyor", 32'(conveyor_signal), 1);
        fill_en = 1'b0;
        @(negedge clk_1khz);
        rst_n = 1'b1;
        clear_stats();
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk_1khz);
            if (hopper_level) n_high++;
        end
        check_val("e_no_residual", n_high, 0);

        // Jam outside a move only drops conveyor_signal
        inject_conveyor_jam = 1'b1;
        @(negedge clk_1khz);
        check_val("f_conveyor", 32'(conveyor_signal), 0);
        check_val("f_bottle", 32'(bottle_in_place), 1);
        inject_conveyor_jam = 1'b0;

        // Injected empty stalls feeding until released
        inject_hopper_empty = 1'b1;
        fill_en = 1'b1;
        #1;
        check_val("g_empty", 32'(hopper_empty), 1);
        repeat (3) @(negedge clk_1khz);
        check_val("g_stalled", 32'(hopper_level), 0);
        check_val("g_count", 32'(hopper_count), 3);
        inject_hopper_empty = 1'b0;
        @(negedge clk_1khz);
        check_val("g_resume", 32'(hopper_level), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
